// File: rtl/ram.sv
// Single-port synchronous RAM with registered read data.
// A write or a read happens only when exactly one of WrEn/RdEn is high.
module ram #(
  parameter int ADDRESS = 3,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   WrData,
  input  logic [ADDRESS-1:0] Address,
  input  logic               RdEn,
  input  logic               WrEn,
  output logic [WIDTH-1:0]   RdData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_go;
  logic             rd_go;

  // Both enables high is treated as idle, so reads and writes never collide.
  assign wr_go = WrEn & ~RdEn;
  assign rd_go = RdEn & ~WrEn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_go) begin
      mem[Address] <= WrData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RdData <= '0;
    end else if (rd_go) begin
      RdData <= mem[Address];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: write/read, enable decoding, reset and sweep.
module tb_ram;

  localparam int ADDRESS = 3;
  localparam int DEPTH   = 8;
  localparam int WIDTH   = 16;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   WrData;
  logic [ADDRESS-1:0] Address;
  logic               RdEn;
  logic               WrEn;
  logic [WIDTH-1:0]   RdData;

  int errors = 0;
  int checks = 0;

  ram #(.ADDRESS(ADDRESS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .WrData (WrData),
    .Address(Address),
    .RdEn   (RdEn),
    .WrEn   (WrEn),
    .RdData (RdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] expv);
    checks++;
    assert (RdData === expv) else begin
      errors++;
      $error("FAIL %s: RdData=%h expected %h", tag, RdData, expv);
    end
  endtask

  task automatic do_write(input logic [ADDRESS-1:0] a, input logic [WIDTH-1:0] d);
    Address = a; WrData = d; WrEn = 1'b1; RdEn = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [ADDRESS-1:0] a);
    Address = a; WrEn = 1'b0; RdEn = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; WrData = '0; Address = '0; RdEn = 1'b0; WrEn = 1'b0;
    #1;
    check("reset_rddata", 16'h0000);
    tick(); tick();
    rst = 1'b1;

    // Basic write/read; a write leaves RdData alone.
    do_write(3'd0, 16'hF3F3);
    check("write_holds_rd", 16'h0000);
    do_read(3'd0);
    check("read_a0", 16'hF3F3);

    // Both enables high: no write, no read.
    Address = 3'd1; WrData = 16'h0033; WrEn = 1'b1; RdEn = 1'b1;
    tick();
    check("both_hi_c1", 16'hF3F3);
    tick();
    check("both_hi_c2", 16'hF3F3);
    do_read(3'd1);
    check("both_hi_nowrite", 16'h0000);

    do_write(3'd1, 16'h00FF);
    do_read(3'd1);
    check("read_a1", 16'h00FF);
    do_read(3'd0);
    check("read_a0_again", 16'hF3F3);

    // Asynchronous reset: RdData clears without a clock edge.
    do_read(3'd1);
    rst = 1'b0;
    #1;
    check("rst_async", 16'h0000);
    tick();
    check("rst_held_read", 16'h0000);
    // A write attempted while reset is held must not land.
    Address = 3'd2; WrData = 16'hDEAD; WrEn = 1'b1; RdEn = 1'b0;
    tick();
    Address = 3'd1; WrEn = 1'b0; RdEn = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_release_read", 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(ADDRESS'(i));
      check($sformatf("rst_clear_a%0d", i), 16'h0000);
    end

    // Idle hold while Address moves.
    do_write(3'd5, 16'hF57F);
    do_read(3'd5);
    check("read_a5", 16'hF57F);
    WrEn = 1'b0; RdEn = 1'b0; Address = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_hold_%0d", i), 16'hF57F);
    end

    // Full sweep of distinct patterns.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(ADDRESS'(i), 16'hA500 + 16'(i));
    end
    check("sweep_write_holds", 16'hF57F);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      do_read(ADDRESS'(i));
      check($sformatf("sweep_a%0d", i), 16'hA500 + 16'(i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
